// File: rtl/icy_dsp_pkg.sv
// Shared receive-DSP definitions: default sample widths, clip-window length,
// full-scale code helpers and the sample classification type.
package icy_dsp_pkg;

   localparam int unsigned ISZ_DEF      = 12;
   localparam int unsigned OSZ_DEF      = 17;
   localparam int unsigned WIN_LOG2_DEF = 10;

   // Classification of an ADC code against the converter's full-scale rails.
   typedef enum logic [1:0] {
      CLS_IN_RANGE = 2'd0,
      CLS_POS_FS   = 2'd1,
      CLS_NEG_FS   = 2'd2
   } sample_class_e;

   // Largest positive code of a w-bit two's complement sample: 0111...1
   function automatic logic [31:0] max_code(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Most negative code of a w-bit two's complement sample: 1000...0
   function automatic logic [31:0] min_code(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/clip_window_monitor.sv
// Clip monitor: counts full-scale ADC codes over windows of 2**WIN_LOG2
// accepted samples and publishes the count and a threshold flag at each close.
// Optional macro ADC_SAMPLE_EXPANDER_PEAK_EN adds per-window peak |sample|.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   accept_i        strobe: sample_i is accepted this cycle
//   sample_i        signed ADC sample
//   clip_thresh_i   threshold, sampled at window close
//   clip_count_o    clip count of last completed window
//   clip_flag_o     clip_count_o >= threshold at close
//   win_done_o      one-cycle pulse after each window close
//   peak_o          (macro only) largest |sample| of last completed window
module clip_window_monitor
   import icy_dsp_pkg::*;
#(
   parameter int unsigned ISZ      = ISZ_DEF,
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
   parameter int unsigned CNT_W    = WIN_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept_i,
   input  logic [ISZ-1:0]   sample_i,
   input  logic [CNT_W-1:0] clip_thresh_i,
   output logic [CNT_W-1:0] clip_count_o,
   output logic             clip_flag_o,
   output logic             win_done_o
`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
  ,output logic [ISZ-2:0]   peak_o
`endif
);

   localparam logic [ISZ-1:0] MAX_CODE = ISZ'(max_code(ISZ));
   localparam logic [ISZ-1:0] MIN_CODE = ISZ'(min_code(ISZ));

   sample_class_e          cls;
   logic                   clip;
   logic                   last;
   logic [CNT_W-1:0]       total;
   logic [WIN_LOG2-1:0]    smp_cnt_q, smp_cnt_d;
   logic [CNT_W-1:0]       run_q, run_d;
   logic [CNT_W-1:0]       clip_count_q;
   logic                   clip_flag_q;
   logic                   win_done_q;

   always_comb begin
      cls = CLS_IN_RANGE;
      if (sample_i == MAX_CODE)      cls = CLS_POS_FS;
      else if (sample_i == MIN_CODE) cls = CLS_NEG_FS;
      clip  = (cls != CLS_IN_RANGE);
      // Counter is all-ones on the 2**WIN_LOG2-th sample; it wraps to zero
      // on that accept, so the closing sample lands in the closing window.
      last  = accept_i && (smp_cnt_q == '1);
      total = run_q + CNT_W'(clip);
      smp_cnt_d = accept_i ? smp_cnt_q + 1'b1 : smp_cnt_q;
      run_d     = last ? '0 : (accept_i ? total : run_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_cnt_q    <= '0;
         run_q        <= '0;
         clip_count_q <= '0;
         clip_flag_q  <= 1'b0;
         win_done_q   <= 1'b0;
      end else begin
         smp_cnt_q  <= smp_cnt_d;
         run_q      <= run_d;
         win_done_q <= last;
         if (last) begin
            clip_count_q <= total;
            clip_flag_q  <= (total >= clip_thresh_i);
         end
      end
   end

   assign clip_count_o = clip_count_q;
   assign clip_flag_o  = clip_flag_q;
   assign win_done_o   = win_done_q;

`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
   logic [ISZ-2:0] mag;
   logic [ISZ-2:0] pk_max;
   logic [ISZ-2:0] run_pk_q, run_pk_d;
   logic [ISZ-2:0] peak_q;

   always_comb begin
      // Negative full scale has no positive twin; saturate its magnitude.
      if (cls == CLS_NEG_FS)        mag = '1;
      else if (sample_i[ISZ-1])     mag = ~sample_i[ISZ-2:0] + 1'b1;
      else                          mag = sample_i[ISZ-2:0];
      pk_max   = (mag > run_pk_q) ? mag : run_pk_q;
      run_pk_d = last ? '0 : (accept_i ? pk_max : run_pk_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_pk_q <= '0;
         peak_q   <= '0;
      end else begin
         run_pk_q <= run_pk_d;
         if (last) peak_q <= pk_max;
      end
   end

   assign peak_o = peak_q;
`endif

endmodule

// File: rtl/adc_sample_expander.sv
// ADC sample expander: widens signed ISZ-bit ADC samples to OSZ bits with a
// programmable power-of-two gain, behind a one-stage valid/ready pipeline,
// and monitors full-scale clipping per window.
// Optional macro ADC_SAMPLE_EXPANDER_PEAK_EN adds the peak output.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_data/i_valid/i_ready   upstream handshake (i_ready combinational)
//   shift            left-shift gain, clamped to OSZ-ISZ
//   o_data/o_valid/o_ready   downstream handshake (registered)
//   clip_thresh      clip threshold, sampled at window close
//   clip_count, clip_flag, win_done   window clip report
//   peak             (macro only) largest |i_data| of last window
module adc_sample_expander
   import icy_dsp_pkg::*;
#(
   parameter int unsigned ISZ      = ISZ_DEF,
   parameter int unsigned OSZ      = OSZ_DEF,
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
   parameter int unsigned CNT_W    = WIN_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ISZ-1:0]   i_data,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [2:0]       shift,
   output logic [OSZ-1:0]   o_data,
   output logic             o_valid,
   input  logic             o_ready,
   input  logic [CNT_W-1:0] clip_thresh,
   output logic [CNT_W-1:0] clip_count,
   output logic             clip_flag,
   output logic             win_done
`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
  ,output logic [ISZ-2:0]   peak
`endif
);

   localparam int unsigned SH_MAX = OSZ - ISZ;

   logic           accept;
   int unsigned    sh_eff;
   logic [OSZ-1:0] wide;
   logic [OSZ-1:0] o_data_q, o_data_d;
   logic           o_valid_q, o_valid_d;

   assign i_ready = ~o_valid_q | o_ready;

   always_comb begin
      accept = i_valid & i_ready;
      sh_eff = 32'(shift);
      if (sh_eff > SH_MAX) sh_eff = SH_MAX;
      // Gain is bounded by the headroom, so the shift can never overflow.
      wide     = {{(OSZ-ISZ){i_data[ISZ-1]}}, i_data};
      o_data_d = accept ? (wide <<< sh_eff) : o_data_q;
      if (accept)       o_valid_d = 1'b1;
      else if (o_ready) o_valid_d = 1'b0;
      else              o_valid_d = o_valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
      end else begin
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
      end
   end

   assign o_data  = o_data_q;
   assign o_valid = o_valid_q;

   clip_window_monitor #(
      .ISZ      (ISZ),
      .WIN_LOG2 (WIN_LOG2),
      .CNT_W    (CNT_W)
   ) u_clip_mon (
      .clk           (clk),
      .rst           (rst),
      .accept_i      (accept),
      .sample_i      (i_data),
      .clip_thresh_i (clip_thresh),
      .clip_count_o  (clip_count),
      .clip_flag_o   (clip_flag),
      .win_done_o    (win_done)
`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
     ,.peak_o        (peak)
`endif
   );

endmodule

// File: tb/tb_adc_sample_expander.sv
module tb_adc_sample_expander;

   localparam int unsigned ISZ = 12;
   localparam int unsigned OSZ = 17;
   localparam int unsigned WL  = 3;
   localparam int unsigned CW  = 4;
   localparam int unsigned WIN = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [ISZ-1:0]  i_data;
   logic            i_valid;
   logic            i_ready;
   logic [2:0]      shift;
   logic [OSZ-1:0]  o_data;
   logic            o_valid;
   logic            o_ready;
   logic [CW-1:0]   clip_thresh;
   logic [CW-1:0]   clip_count;
   logic            clip_flag;
   logic            win_done;
`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
   logic [ISZ-2:0]  peak;
`endif

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   adc_sample_expander #(
      .ISZ      (ISZ),
      .OSZ      (OSZ),
      .WIN_LOG2 (WL),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .i_ready     (i_ready),
      .shift       (shift),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_ready     (o_ready),
      .clip_thresh (clip_thresh),
      .clip_count  (clip_count),
      .clip_flag   (clip_flag),
      .win_done    (win_done)
`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
     ,.peak        (peak)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (arithmetic, window as a sample list) --
   function automatic logic [OSZ-1:0] ref_expand(input logic [ISZ-1:0] d, input logic [2:0] s);
      int v, k;
      v = int'($signed(d));
      k = (s > 3'd5) ? 5 : int'(s);
      return OSZ'(v * (2 ** k));
   endfunction

   function automatic bit is_clip(input logic [ISZ-1:0] d);
      return (d == 12'h7FF) || (d == 12'h800);
   endfunction

   function automatic int mag_of(input logic [ISZ-1:0] d);
      int v;
      v = int'($signed(d));
      if (v == -2048) return 2047;
      return (v < 0) ? -v : v;
   endfunction

   bit             m_valid;
   logic [OSZ-1:0] m_data;
   int             m_cnt;
   bit             m_flag;
   bit             m_done;
   int             m_peak;
   logic [ISZ-1:0] win[$];

   // Inputs are driven 1 ns after posedge, so at negedge they show what the
   // next posedge will sample; the model advances one cycle here.
   always @(negedge clk) begin
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_cnt = 0; m_flag = 1'b0;
         m_done = 1'b0; m_peak = 0; win.delete();
      end else begin
         if (win_done) pulses++;
         chk("o_valid", 32'(o_valid), 32'(m_valid));
         chk("o_data", 32'(o_data), 32'(m_data));
         chk("i_ready", 32'(i_ready), 32'(!m_valid || o_ready));
         chk("clip_count", 32'(clip_count), 32'(m_cnt));
         chk("clip_flag", 32'(clip_flag), 32'(m_flag));
         chk("win_done", 32'(win_done), 32'(m_done));
`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
         chk("peak", 32'(peak), 32'(m_peak));
`endif
         m_done = 1'b0;
         if (i_valid && (!m_valid || o_ready)) begin
            m_valid = 1'b1;
            m_data  = ref_expand(i_data, shift);
            win.push_back(i_data);
            if (win.size() == WIN) begin
               m_cnt = 0; m_peak = 0;
               foreach (win[j]) begin
                  if (is_clip(win[j])) m_cnt++;
                  if (mag_of(win[j]) > m_peak) m_peak = mag_of(win[j]);
               end
               m_flag = (m_cnt >= int'(clip_thresh));
               m_done = 1'b1;
               win.delete();
            end
         end else if (o_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers -------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic send_window(input logic [ISZ-1:0] a, input logic [ISZ-1:0] b,
                              input logic [CW-1:0] th);
      clip_thresh = th;
      for (int k = 0; k < int'(WIN); k++) begin
         i_valid = 1'b1;
         i_data  = k[0] ? b : a;
         step();
      end
      i_valid = 1'b0;
   endtask

   typedef struct {
      logic [ISZ-1:0] d;
      logic [2:0]     s;
      logic [OSZ-1:0] e;
   } vec_t;

   vec_t           tv[9];
   logic [ISZ-1:0] wseq[8];
   logic [3:0]     bp_pat;
   bit             acc;

   initial begin
      tv[0] = '{12'h800, 3'd0, 17'h1F800};
      tv[1] = '{12'h001, 3'd5, 17'h00020};
      tv[2] = '{12'h001, 3'd7, 17'h00020};
      tv[3] = '{12'h7FF, 3'd5, 17'h0FFE0};
      tv[4] = '{12'h800, 3'd5, 17'h10000};
      tv[5] = '{12'hFFF, 3'd3, 17'h1FFF8};
      tv[6] = '{12'h123, 3'd1, 17'h00246};
      tv[7] = '{12'h7FF, 3'd0, 17'h007FF};
      tv[8] = '{12'hABC, 3'd6, 17'h15780};
      wseq  = '{12'h7FF, 12'h000, 12'h800, 12'h123, 12'h7FF, 12'h000, 12'h000, 12'h7FF};
      bp_pat = 4'b1001;

      rst = 1'b1; i_valid = 1'b0; i_data = '0; shift = '0;
      o_ready = 1'b1; clip_thresh = 4'd4;
      #12;
      chk("rst_o_valid", 32'(o_valid), 0);
      chk("rst_o_data", 32'(o_data), 0);
      chk("rst_clip_count", 32'(clip_count), 0);
      chk("rst_clip_flag", 32'(clip_flag), 0);
      chk("rst_win_done", 32'(win_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Widen/gain table, back to back, one-cycle latency.
      for (int k = 0; k < 9; k++) begin
         i_valid = 1'b1; i_data = tv[k].d; shift = tv[k].s;
         step();
         chk("lat_valid", 32'(o_valid), 1);
         chk("widen", 32'(o_data), 32'(tv[k].e));
      end
      i_valid = 1'b0; shift = 3'd0;
      step();

      // Window count: 4 clips among 8 samples.
      do_reset();
      clip_thresh = 4'd4;
      for (int k = 0; k < 8; k++) begin
         i_valid = 1'b1; i_data = wseq[k];
         step();
         if (k < 7) chk("win_early", 32'(win_done), 0);
      end
      i_valid = 1'b0;
      chk("win_done_pulse", 32'(win_done), 1);
      chk("win_count", 32'(clip_count), 4);
      chk("win_flag", 32'(clip_flag), 1);
      step();
      chk("win_done_once", 32'(win_done), 0);
      chk("win_count_hold", 32'(clip_count), 4);

      // Threshold edges.
      send_window(12'h7FF, 12'h800, 4'd9);
      chk("th9_count", 32'(clip_count), 8);
      chk("th9_flag", 32'(clip_flag), 0);
      send_window(12'h7FF, 12'h800, 4'd8);
      chk("th8_count", 32'(clip_count), 8);
      chk("th8_flag", 32'(clip_flag), 1);
      send_window(12'h000, 12'h055, 4'd0);
      chk("th0_count", 32'(clip_count), 0);
      chk("th0_flag", 32'(clip_flag), 1);

      // Reset after 5 accepts of a fresh window.
      for (int k = 0; k < 5; k++) begin
         i_valid = 1'b1; i_data = 12'h7FF;
         step();
      end
      i_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_o_valid", 32'(o_valid), 0);
      chk("mid_rst_o_data", 32'(o_data), 0);
      chk("mid_rst_flag", 32'(clip_flag), 0);
      chk("mid_rst_count", 32'(clip_count), 0);
      chk("mid_rst_win_done", 32'(win_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         i_valid = 1'b1; i_data = 12'h800;
         step();
      end
      i_valid = 1'b0;
      step();
      chk("post_rst_7", pulses, 0);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      step();
      chk("post_rst_8", pulses, 1);
      chk("post_rst_count", 32'(clip_count), 8);

      // Backpressure: o_ready 1,0,0,1 with continuous valid.
      do_reset();
      i_data = 12'h010;
      for (int k = 0; k < 24; k++) begin
         i_valid = 1'b1;
         o_ready = bp_pat[k % 4];
         #1;
         acc = i_ready;
         step();
         if (acc) i_data = i_data + 12'h001;
      end
      i_valid = 1'b0; o_ready = 1'b1;
      step();

      // Randomized traffic.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         int r;
         i_valid = ($urandom_range(0, 3) != 0);
         o_ready = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 5));
         if (r == 0)      i_data = 12'h7FF;
         else if (r == 1) i_data = 12'h800;
         else             i_data = 12'($urandom);
         shift = 3'($urandom);
         clip_thresh = 4'($urandom_range(0, 10));
         step();
      end
      i_valid = 1'b0; o_ready = 1'b1;
      step();

`ifdef ADC_SAMPLE_EXPANDER_PEAK_EN
      do_reset();
      for (int k = 0; k < 8; k++) begin
         i_valid = 1'b1;
         i_data = (k == 3) ? 12'h800 : 12'h010;
         step();
      end
      i_valid = 1'b0;
      chk("peak_min", 32'(peak), 32'h7FF);
      for (int k = 0; k < 8; k++) begin
         i_valid = 1'b1;
         i_data = (k == 2) ? 12'h123 : ((k == 5) ? 12'hEE0 : 12'h005);
         step();
      end
      i_valid = 1'b0;
      chk("peak_123", 32'(peak), 32'h123);
`endif

      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_sample_expander.md
Name: adc_sample_expander

Overview:
- Receive-side counterpart of the transmit saturator: takes narrow signed ADC samples (ISZ bits) and widens them to the DSP word width (OSZ bits) with a programmable power-of-two gain.
- Monitors ADC full-scale clipping over fixed sample windows and reports the clip count and a threshold flag.
- Sits between the ADC capture interface and the receive DSP chain, using valid/ready handshakes on both sides.

Parameters:
- ISZ, 12, input sample width (signed two's complement).
- OSZ, 17, output sample width; must be >= ISZ+1.
- WIN_LOG2, 10, clip-monitor window length is 2**WIN_LOG2 accepted samples.
- CNT_W, WIN_LOG2+1, width of the clip counters; holds the value 2**WIN_LOG2.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous reset, active-high.
- i_data  in  ISZ  signed ADC sample.
- i_valid  in  1  i_data is valid.
- i_ready  out  1  block accepts i_data this cycle.
- shift  in  3  left-shift gain, 0..7; values above OSZ-ISZ are clamped to OSZ-ISZ.
- o_data  out  OSZ  signed widened sample.
- o_valid  out  1  o_data is valid.
- o_ready  in  1  downstream accepts o_data.
- clip_thresh  in  CNT_W  clip-count threshold.
- clip_count  out  CNT_W  clip count of the last completed window.
- clip_flag  out  1  last window clip_count >= clip_thresh.
- win_done  out  1  one-cycle pulse when clip_count and clip_flag update.

Behaviour:
- Reset (asynchronous, active-high):
  - o_valid=0, o_data=0, clip_count=0, clip_flag=0, win_done=0.
  - Sample counter=0, running clip counter=0.
  - Any partial window is discarded.
- Handshake:
  - i_ready = ~o_valid | o_ready (combinational; one-stage pipeline, no skid buffer).
  - Transfer in when i_valid & i_ready.
  - o_valid holds, and o_data stays stable, until o_ready is seen.
- Datapath:
  - On each accepted input, o_data <= sign_extend(i_data, OSZ) <<< shift_eff, with zero fill on the right.
  - shift_eff = min(shift, OSZ-ISZ), sampled on the accept cycle.
  - The result cannot overflow by construction; no saturation is needed.
  - Latency: accept at cycle N gives o_valid=1 at N+1.
  - If there is no new accept while o_ready=1 and o_valid=1, o_valid drops to 0.
- Clip detect: an accepted sample is clipped if i_data == {0,1...1} (max) or i_data == {1,0...0} (min).
- Window logic:
  - The sample counter increments once per accepted sample. Backpressure stalls do not count.
  - On the accept that brings the count to 2**WIN_LOG2:
    - clip_count <= running count plus this sample's clip bit.
    - clip_flag <= (that value >= clip_thresh).
    - win_done = 1 on the next cycle only.
    - Sample counter and running count restart at 0; the closing sample belongs to the closed window.
- clip_thresh:
  - Sampled at window close only.
  - clip_thresh=0 forces clip_flag=1 at every close.
  - clip_thresh > 2**WIN_LOG2 forces clip_flag=0.
- clip_count and clip_flag hold their values between windows.

Optional Feature:
- Macro: ADC_SAMPLE_EXPANDER_PEAK_EN.
- Defined:
  - Adds output port peak, ISZ-1 bits: the largest |i_data| seen in the last completed window.
  - |min code| saturates to 2**(ISZ-1)-1.
  - peak updates on the same window close as clip_count, including the closing sample, and resets to 0.
  - The running peak restarts at 0 each window.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package icy_dsp_pkg:
  - Default ISZ/OSZ.
  - Functions for the sample max/min code constants.
  - WIN_LOG2 default.
- One sub-module: clip_window_monitor.
  - Owns the sample counter, running clip count, threshold compare and win_done.
  - Also owns peak tracking under the macro.
  - Driven by an accept strobe plus the sample.
- The top level holds the handshake and shift datapath.

Test Plan:
- Widen and gain, shift=0 vs shift=5:
  - shift=0, i_data=0x800 (-2048) -> o_data=0x1F800.
  - shift=5, i_data=0x001 -> o_data=0x00020.
  - shift=7 behaves as shift=5.
  - Latency is 1 cycle.
- Backpressure: i_valid=1 continuous, o_ready toggling 1,0,0,1 -> i_ready follows; o_data held while stalled; no sample dropped or duplicated; sample counter unchanged during stalls.
- Window count, with WIN_LOG2=3:
  - Sample sequence 0x7FF,0x000,0x800,0x123,0x7FF,0x000,0x000,0x7FF (the eighth closes the window), clip_thresh=4.
  - Result: clip_count=4, clip_flag=1, win_done pulses once, one cycle after the 8th accept.
- Threshold edges, with WIN_LOG2=3 and all 8 samples clipped:
  - clip_thresh=9 -> flag=0.
  - clip_thresh=8 -> flag=1, clip_count=8.
  - clip_thresh=0 with no clips -> flag=1, clip_count=0.
- Reset mid-operation, with WIN_LOG2=3:
  - Assert rst after 5 accepts: outputs are 0 immediately.
  - After release, 8 fresh accepts are needed before win_done.
- With ADC_SAMPLE_EXPANDER_PEAK_EN and WIN_LOG2=3:
  - Window containing 0x800 -> peak=0x7FF.
  - Next window with max |x|=0x0123 -> peak=0x123.
